// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state encoding and access-size constants for the RAM arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational two-way winner picker
// On a tie the port named by i_ptr wins; a lone request always wins.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_grant
);

  always_comb begin
    o_grant = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_grant = i_ptr;
    end else if (i_valid1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester RAM arbiter with timeout (round-robin when RAM_ARB_RR_EN is defined)
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        m0_valid,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  output logic        s_write,
  output logic [31:0] s_addr,
  output logic [1:0]  s_size,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic               r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_s_valid;
  logic               r_s_write;
  logic [31:0]        r_s_addr;
  logic [1:0]         r_s_size;
  logic [31:0]        r_s_wdata;
  logic               r_m0_ready;
  logic [31:0]        r_m0_rdata;
  logic               r_m0_err;
  logic               r_m1_ready;
  logic [31:0]        r_m1_rdata;
  logic               r_m1_err;
  logic               w_grant;
  logic               w_ptr;
  logic               w_any_valid;

  assign w_any_valid = m0_valid || m1_valid;

`ifdef RAM_ARB_RR_EN
  logic r_ptr;

  // Pointer moves to the loser so it wins the next tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr <= 1'b0;
    end else if (r_state == IDLE && w_any_valid) begin
      r_ptr <= ~w_grant;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  ram_arb_pick u_pick (
    .i_valid0 (m0_valid),
    .i_valid1 (m1_valid),
    .i_ptr    (w_ptr),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_cnt      <= '0;
      r_s_valid  <= 1'b0;
      r_s_write  <= 1'b0;
      r_s_addr   <= '0;
      r_s_size   <= '0;
      r_s_wdata  <= '0;
      r_m0_ready <= 1'b0;
      r_m0_rdata <= '0;
      r_m0_err   <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m1_rdata <= '0;
      r_m1_err   <= 1'b0;
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant   <= w_grant;
            r_s_write <= w_grant ? m1_write : m0_write;
            r_s_addr  <= w_grant ? m1_addr  : m0_addr;
            r_s_size  <= w_grant ? m1_size  : m0_size;
            r_s_wdata <= w_grant ? m1_wdata : m0_wdata;
            r_s_valid <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_s_valid <= 1'b0;
          r_cnt     <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // The completion pulse is raised here so it is visible during RESP.
          if (s_ready) begin
            if (r_grant) begin
              r_m1_rdata <= s_rdata;
              r_m1_err   <= 1'b0;
              r_m1_ready <= 1'b1;
            end else begin
              r_m0_rdata <= s_rdata;
              r_m0_err   <= 1'b0;
              r_m0_ready <= 1'b1;
            end
            r_state <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            if (r_grant) begin
              r_m1_rdata <= '0;
              r_m1_err   <= 1'b1;
              r_m1_ready <= 1'b1;
            end else begin
              r_m0_rdata <= '0;
              r_m0_err   <= 1'b1;
              r_m0_ready <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_valid  = r_s_valid;
  assign s_write  = r_s_write;
  assign s_addr   = r_s_addr;
  assign s_size   = r_s_size;
  assign s_wdata  = r_s_wdata;
  assign m0_ready = r_m0_ready;
  assign m0_rdata = r_m0_rdata;
  assign m0_err   = r_m0_err;
  assign m1_ready = r_m1_ready;
  assign m1_rdata = r_m1_rdata;
  assign m1_err   = r_m1_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstb;
  logic        m0_valid, m0_write, m1_valid, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_size, m1_size;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_write, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_size;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:15];
  logic        ram_pend;
  logic        ram_stall;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rstb(rstb),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_size(s_size),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  // RAM answers one cycle after it sees s_valid, unless stalled.
  always @(negedge clk) begin
    s_ready = 1'b0;
    if (ram_pend && !ram_stall) begin
      s_ready = 1'b1;
      s_rdata = mem[s_addr[5:2]];
      if (s_write) begin
        case (s_size)
          SZ_BYTE: mem[s_addr[5:2]][8*s_addr[1:0] +: 8]  = s_wdata[7:0];
          SZ_HALF: mem[s_addr[5:2]][16*s_addr[1] +: 16]  = s_wdata[15:0];
          default: mem[s_addr[5:2]] = s_wdata;
        endcase
      end
    end
    ram_pend = s_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input bit p, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    bit other_rdy;
    other_rdy = 1'b0;
    @(negedge clk);
    if (p) begin
      m1_valid = 1'b1; m1_write = w; m1_addr = a; m1_size = sz; m1_wdata = wd;
    end else begin
      m0_valid = 1'b1; m0_write = w; m0_addr = a; m0_size = sz; m0_wdata = wd;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (p ? m0_ready : m1_ready) other_rdy = 1'b1;
    end while (!(p ? m1_ready : m0_ready) && lat < 100);
    rd = p ? m1_rdata : m0_rdata;
    er = p ? m1_err : m0_err;
    if (p) m1_valid = 1'b0; else m0_valid = 1'b0;
    check("other_port_ready_quiet", 32'(other_rdy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          saw_rdy;
    int          n0, n1, k, guard;
    bit          order [0:7];

    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344;
    ram_pend = 1'b0; ram_stall = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_valid = 0; m0_write = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_valid = 0; m1_write = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_m0_err", 32'(m0_err), 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    rstb = 1'b1;

    do_txn(1'b1, 1'b0, 32'h10, SZ_WORD, 32'h0, rd, er, lat);
    check("read_latency", 32'(lat), 32'd3);
    check("read_rdata", rd, 32'hDEADBEEF);
    check("read_err", 32'(er), 32'd0);

    do_txn(1'b0, 1'b1, 32'h21, SZ_BYTE, 32'hAB, rd, er, lat);
    check("bytewr_latency", 32'(lat), 32'd3);
    check("bytewr_s_addr_held", s_addr, 32'h21);
    check("bytewr_s_size_held", 32'(s_size), 32'(SZ_BYTE));
    check("bytewr_s_write_held", 32'(s_write), 32'd1);
    do_txn(1'b0, 1'b0, 32'h20, SZ_WORD, 32'h0, rd, er, lat);
    check("byte_merge_rdata", rd, 32'h1122AB44);
    check("m1_rdata_hold", m1_rdata, 32'hDEADBEEF);

    ram_stall = 1'b1;
    do_txn(1'b0, 1'b0, 32'h10, SZ_WORD, 32'h0, rd, er, lat);
    check("timeout_latency", 32'(lat), 32'd18);
    check("timeout_err", 32'(er), 32'd1);
    check("timeout_rdata", rd, 32'd0);
    ram_stall = 1'b0;
    do_txn(1'b0, 1'b0, 32'h10, SZ_WORD, 32'h0, rd, er, lat);
    check("after_timeout_latency", 32'(lat), 32'd3);
    check("after_timeout_err", 32'(er), 32'd0);
    check("after_timeout_rdata", rd, 32'hDEADBEEF);

    // Abort a transaction parked in WAIT by reset.
    ram_stall = 1'b1;
    @(negedge clk);
    m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h10; m1_size = SZ_WORD;
    @(negedge clk);
    check("abort_issue_s_valid", 32'(s_valid), 32'd1);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    check("abort_s_valid", 32'(s_valid), 32'd0);
    saw_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ready || m1_ready) saw_rdy = 1'b1;
    end
    m1_valid = 1'b0;
    ram_stall = 1'b0;
    rstb = 1'b1;
    check("abort_no_ready", 32'(saw_rdy), 32'd0);
    check("abort_m1_rdata_cleared", m1_rdata, 32'd0);
    do_txn(1'b1, 1'b0, 32'h10, SZ_WORD, 32'h0, rd, er, lat);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("post_reset_rdata", rd, 32'hDEADBEEF);

    pulse_reset();
    @(negedge clk);
    m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h00; m0_size = SZ_WORD;
    m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h30; m1_size = SZ_WORD;
    n0 = 0; n1 = 0; k = 0; guard = 0;
    while ((n0 < 4 || n1 < 4) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (m0_ready && k < 8) begin
        order[k] = 1'b0; k++;
        check("cont_m0_rdata", m0_rdata, 32'hC0DE0000 | 32'(n0));
        n0++;
        if (n0 < 4) m0_addr = 32'(4 * n0); else m0_valid = 1'b0;
      end
      if (m1_ready && k < 8) begin
        order[k] = 1'b1; k++;
        check("cont_m1_rdata", m1_rdata, 32'hC0DE0000 | 32'(12 + n1));
        n1++;
        if (n1 < 4) m1_addr = 32'h30 + 32'(4 * n1); else m1_valid = 1'b0;
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    check("cont_completed", 32'(k), 32'd8);
    for (int i = 0; i < k; i++) begin
`ifdef RAM_ARB_RR_EN
      check($sformatf("cont_grant_%0d", i), 32'(order[i]), 32'(i % 2));
`else
      check($sformatf("cont_grant_%0d", i), 32'(order[i]), (i < 4) ? 32'd0 : 32'd1);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
